// File: rtl/imem_loader.sv
// Writable instruction store with a byte-stream loader and a combinational fetch port.
// Optional checksum byte at the end of the stream is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned         DEPTH    = 128,
  parameter int unsigned         ADDR_W   = 7,
  parameter logic         [15:0] NOP_WORD = 16'hBF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] address,
  output logic [15:0] instruction,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [7:0]  prog_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA_LO,
    S_DATA_HI,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  wptr_q, wptr_d;
  logic [7:0]  prog_len_q, prog_len_d;
  logic        mem_we;
  logic        accept;
  logic [15:0] n_full;
  logic [15:0] mem_q [DEPTH];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      lo_q       <= '0;
      wptr_q     <= '0;
      prog_len_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      lo_q       <= lo_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Code memory is deliberately not reset; prog_len alone gates visibility.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= {rx_data, lo_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    lo_d       = lo_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    mem_we     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    n_full     = {rx_data, n_q};

    rx_ready = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
               (state_q == S_DATA_LO) || (state_q == S_DATA_HI)
`ifdef IMEM_LOADER_CHECKSUM_EN
               || (state_q == S_CHECK)
`endif
               ;
    accept = rx_valid && rx_ready;

    if (start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR))) begin
      state_d    = S_CNT_LO;
      prog_len_d = '0;
      wptr_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = '0;
`endif
    end else if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d = csum_q ^ rx_data;
`endif
      case (state_q)
        S_CNT_LO: begin
          n_d     = rx_data;
          state_d = S_CNT_HI;
        end
        S_CNT_HI: begin
          if ((n_full == 16'd0) || (n_full > 16'(DEPTH))) state_d = S_ERR;
          else                                            state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          lo_d    = rx_data;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 8'd1;
          if ((wptr_q + 8'd1) == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d    = S_DONE;
            prog_len_d = n_q;
`endif
          end else begin
            state_d = S_DATA_LO;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (rx_data == csum_q) begin
            state_d    = S_DONE;
            prog_len_d = n_q;
          end else begin
            state_d = S_ERR;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end

    cpu_hold    = rx_ready;
    done        = (state_q == S_DONE);
    err         = (state_q == S_ERR);
    prog_len    = prog_len_q;
    // prog_len never exceeds DEPTH, so the compare also rejects out-of-range addresses.
    instruction = (address < {8'd0, prog_len_q}) ? mem_q[address[ADDR_W-1:0]] : NOP_WORD;
  end

endmodule
